// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared types and defaults for the AXI4-Lite command-port arbiter
// Contents: arb_state_e (arbiter FSM states), DEF_ADDR_W / DEF_DATA_W default widths.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner selection
// Ports:
//   req       in   NUM_REQ  pending request vector
//   ptr       in   IDX_W    highest-priority index for this pick
//   winner    out  IDX_W    first requester at or after ptr (mod NUM_REQ)
//   any_valid out  1        at least one request pending
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  int               idx;
  logic [IDX_W-1:0] cand;

  // Walk ptr, ptr+1, ... with wraparound; the first hit wins and later hits are ignored.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = IDX_W'(idx);
      if (!any_valid && req[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_master_arbiter.sv
// rtl/axi4_lite_master_arbiter.sv - round-robin sharing of one AXI4-Lite master command port
// Ports:
//   ACLK, ARESET                      clock, asynchronous active-high reset
//   req_valid/write/addr/wdata        per-requester command inputs (addr/wdata flattened)
//   req_done, req_err, rsp_rdata      one-hot completion pulse, timeout flag, read data
//   busy, grant_id                    arbiter activity and current/last owner
//   m_transfer/write/addr/wdata       registered command toward the master
//   m_ready, m_rdata                  master completion pulse and read data
module axi4_lite_master_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_done,
  output logic                        req_err,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        m_transfer,
  output logic                        m_write,
  output logic [ADDR_W-1:0]           m_addr,
  output logic [DATA_W-1:0]           m_wdata,
  input  logic                        m_ready,
  input  logic [DATA_W-1:0]           m_rdata
);

  localparam int GW = $clog2(NUM_REQ);
  // Keep the counter at least one bit wide so TIMEOUT=0 (disabled) still elaborates.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e      state, state_nxt;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   pick_id;
  logic            pick_any;
  logic [CW-1:0]   wait_cnt;
  logic            timed_out;
  logic            err_q;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GW)
  ) u_picker (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .winner    (pick_id),
    .any_valid (pick_any)
  );

  assign timed_out = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // m_ready is checked before the timeout so a completion on the last allowed cycle succeeds.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (pick_any) state_nxt = ARB_ISSUE;
      ARB_ISSUE: state_nxt = ARB_WAIT;
      ARB_WAIT:  if (m_ready || timed_out) state_nxt = ARB_RESP;
      ARB_RESP:  state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // The master relaunches on every high cycle of m_transfer, so it is a pure ISSUE decode.
  always_comb begin
    m_transfer = (state == ARB_ISSUE);
    busy       = (state != ARB_IDLE);
    req_done   = '0;
    req_err    = 1'b0;
    if (state == ARB_RESP) begin
      req_done[grant_id] = 1'b1;
      req_err            = err_q;
    end
  end

  // Command/response registers, timeout counter and round-robin pointer.
  // m_ready outside WAIT (late completion after a timeout) falls through untouched.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      m_write   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      wait_cnt  <= '0;
      rsp_rdata <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_id <= pick_id;
            m_write  <= req_write[pick_id];
            m_addr   <= req_addr[pick_id*ADDR_W +: ADDR_W];
            m_wdata  <= req_wdata[pick_id*DATA_W +: DATA_W];
          end
        end
        ARB_ISSUE: begin
          wait_cnt <= '0;
        end
        ARB_WAIT: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (m_ready) begin
            rsp_rdata <= m_write ? '0 : m_rdata;
            err_q     <= 1'b0;
          end else if (timed_out) begin
            rsp_rdata <= '0;
            err_q     <= 1'b1;
          end
        end
        ARB_RESP: begin
          rr_ptr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// tb/tb_axi4_lite_master_arbiter.sv - self-checking bench for axi4_lite_master_arbiter
module tb_axi4_lite_master_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic                       ACLK = 1'b0;
  logic                       ARESET = 1'b1;
  logic [NUM_REQ-1:0]         req_valid = '0;
  logic [NUM_REQ-1:0]         req_write = '0;
  logic [NUM_REQ*ADDR_W-1:0]  req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0]  req_wdata = '0;
  logic [NUM_REQ-1:0]         req_done;
  logic                       req_err;
  logic [DATA_W-1:0]          rsp_rdata;
  logic                       busy;
  logic [0:0]                 grant_id;
  logic                       m_transfer;
  logic                       m_write;
  logic [ADDR_W-1:0]          m_addr;
  logic [DATA_W-1:0]          m_wdata;
  logic                       m_ready = 1'b0;
  logic [DATA_W-1:0]          m_rdata = '0;

  always #5 ACLK = ~ACLK;

  axi4_lite_master_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_done   (req_done),
    .req_err    (req_err),
    .rsp_rdata  (rsp_rdata),
    .busy       (busy),
    .grant_id   (grant_id),
    .m_transfer (m_transfer),
    .m_write    (m_write),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_ready    (m_ready),
    .m_rdata    (m_rdata)
  );

  // mlat: cycles from m_transfer to m_ready (-1 = master never answers).
  typedef struct {
    logic [1:0]  wr;
    int          n0;
    int          n1;
    int          mlat;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] rbase;
  } vec_t;

  typedef struct {
    int          owner;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        cmd_q[$];
  exp_t        rsp_q[$];
  vec_t        vecs[7];
  vec_t        cur;
  vec_t        v_rst;
  vec_t        v_fin;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          t_xfer = 0;
  int          mcnt = 0;
  int          mlat = 0;
  int          exp_ptr = 0;
  int          kcnt[2];
  int          ntot[2];
  logic [31:0] rbase = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] base_addr(input vec_t v, input int i);
    return (i == 0) ? v.a0 : v.a1;
  endfunction

  function automatic logic [31:0] base_data(input vec_t v, input int i);
    return (i == 0) ? v.d0 : v.d1;
  endfunction

  task automatic present(input int i, input int k);
    req_addr[i*ADDR_W +: ADDR_W]  = base_addr(cur, i) + 4'(k);
    req_wdata[i*DATA_W +: DATA_W] = base_data(cur, i) + 32'(k);
    req_write[i]                  = cur.wr[i];
    req_valid[i]                  = 1'b1;
  endtask

  // One clock: sample at the falling edge, score, then drive requesters and the master model.
  task automatic tick();
    exp_t e;
    @(negedge ACLK);
    cyc++;
    if (m_transfer) begin
      if (cmd_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_transfer: got m_transfer=1, want 0 (cycle %0d)", cyc);
      end else begin
        e = cmd_q.pop_front();
        chk("grant_id", 32'(grant_id), 32'(e.owner));
        chk("m_write", 32'(m_write), 32'(e.wr));
        chk("m_addr", 32'(m_addr), 32'(e.addr));
        chk("m_wdata", m_wdata, e.wdata);
      end
      t_xfer = cyc;
    end
    if (req_done != '0) begin
      if (rsp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got req_done=%b, want 00 (cycle %0d)", req_done, cyc);
      end else begin
        e = rsp_q.pop_front();
        chk("req_done", 32'(req_done), 32'(1 << e.owner));
        chk("req_err", 32'(req_err), 32'(e.err));
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("latency", 32'(cyc - t_xfer), 32'(e.lat));
        kcnt[e.owner]++;
        if (kcnt[e.owner] < ntot[e.owner]) present(e.owner, kcnt[e.owner]);
        else req_valid[e.owner] = 1'b0;
      end
    end
    m_ready = 1'b0;
    m_rdata = $urandom;
    if (m_transfer) begin
      mcnt = mlat;
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        m_ready = 1'b1;
        m_rdata = rbase ^ {28'h0, m_addr};
      end
    end
  endtask

  // Predict the grant order (round robin, pointer = last owner + 1) and push expectations.
  task automatic start_vec(input vec_t v);
    int   p[2];
    int   k[2];
    int   ptr;
    int   o;
    logic err;
    exp_t e;
    cur     = v;
    mlat    = v.mlat;
    rbase   = v.rbase;
    ntot[0] = v.n0;
    ntot[1] = v.n1;
    kcnt[0] = 0;
    kcnt[1] = 0;
    p[0]    = v.n0;
    p[1]    = v.n1;
    k[0]    = 0;
    k[1]    = 0;
    ptr     = exp_ptr;
    err     = !(v.mlat >= 1 && v.mlat <= TIMEOUT);
    while (p[0] + p[1] > 0) begin
      o       = (p[ptr] > 0) ? ptr : 1 - ptr;
      e.owner = o;
      e.wr    = v.wr[o];
      e.addr  = base_addr(v, o) + 4'(k[o]);
      e.wdata = base_data(v, o) + 32'(k[o]);
      e.err   = err;
      e.rdata = (err || e.wr) ? 32'h0 : (v.rbase ^ {28'h0, e.addr});
      e.lat   = err ? TIMEOUT + 1 : v.mlat + 1;
      cmd_q.push_back(e);
      rsp_q.push_back(e);
      k[o]++;
      p[o]--;
      ptr = 1 - o;
    end
    exp_ptr = ptr;
    if (v.n0 > 0) present(0, 0);
    if (v.n1 > 0) present(1, 0);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int b;
    start_vec(v);
    b = 0;
    while (rsp_q.size() > 0 && b < 400) begin
      tick();
      b++;
    end
    if (rsp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL vec%0d_budget: got %0d pending responses, want 0", idx, rsp_q.size());
    end
    cmd_q.delete();
    rsp_q.delete();
    req_valid = '0;
  endtask

  initial begin
    //           wr     n0 n1 mlat a0    a1    d0            d1            rbase
    vecs[0] = '{2'b11, 1, 1, 2,  4'h1, 4'h2, 32'h11111111, 32'h22222222, 32'h00000000};
    vecs[1] = '{2'b00, 1, 0, 3,  4'h8, 4'h0, 32'h00000000, 32'h00000000, 32'hDEADBEE7};
    vecs[2] = '{2'b00, 0, 1, 5,  4'h0, 4'h3, 32'h00000000, 32'h33333333, 32'h12345670};
    vecs[3] = '{2'b01, 3, 3, 1,  4'hA, 4'h4, 32'hA0000000, 32'hB0000000, 32'hCAFE0000};
    vecs[4] = '{2'b00, 0, 1, -1, 4'h0, 4'h6, 32'h00000000, 32'h66666666, 32'h55555555};
    vecs[5] = '{2'b00, 1, 0, 8,  4'hC, 4'h0, 32'h0C0C0C0C, 32'h00000000, 32'h0F0F0F00};
    vecs[6] = '{2'b01, 1, 0, 9,  4'hE, 4'h0, 32'hEEEEEEEE, 32'h00000000, 32'h77777777};
    v_rst   = '{2'b00, 0, 1, -1, 4'h0, 4'h5, 32'h00000000, 32'h55AA55AA, 32'h99999999};
    v_fin   = '{2'b00, 1, 1, 4,  4'h7, 4'h9, 32'h70707070, 32'h90909090, 32'h76543210};

    ARESET = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req_done", 32'(req_done), 32'h0);
    chk("rst_req_err", 32'(req_err), 32'h0);
    chk("rst_m_transfer", 32'(m_transfer), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_m_addr", 32'(m_addr), 32'h0);
    chk("rst_m_wdata", m_wdata, 32'h0);
    chk("rst_m_write", 32'(m_write), 32'h0);
    ARESET = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      apply_vec(vecs[i], i);
    end

    // A late m_ready while idle must not produce a completion or disturb the response.
    tick();
    m_ready = 1'b1;
    m_rdata = 32'hBAD0BAD0;
    tick();
    tick();
    chk("late_ready_busy", 32'(busy), 32'h0);
    chk("late_ready_rdata", rsp_rdata, 32'h0);
    chk("late_ready_done", 32'(req_done), 32'h0);

    // Reset in the middle of WAIT: silent abort, pointer back to requester 0.
    start_vec(v_rst);
    for (int i = 0; i < 5; i++) tick();
    chk("mid_wait_busy", 32'(busy), 32'h1);
    chk("mid_wait_grant", 32'(grant_id), 32'h1);
    ARESET = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(req_done), 32'h0);
    chk("abort_grant", 32'(grant_id), 32'h0);
    chk("abort_m_addr", 32'(m_addr), 32'h0);
    cmd_q.delete();
    rsp_q.delete();
    req_valid = '0;
    mcnt      = 0;
    exp_ptr   = 0;
    tick();
    ARESET = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    apply_vec(v_fin, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000 time units");
    $fatal(1);
  end

endmodule
